// File: rtl/zbb_count_unit.sv
// zbb_count_unit: two-stage execute unit for the Zbb CLZ / CTZ / CPOP
// instructions. S1 registers the conditioned operand, S2 registers the
// zero-extended count. A valid/ready pipeline carries a destination tag
// alongside the data and flags the reserved opcode as illegal.
//
// Handshake contract (both ports): a transfer happens on a rising edge where
// valid & ready are both 1. A producer holds valid and its payload steady
// until the transfer. A consumer may drive ready without waiting for valid.
// in_ready is forced low while flush is high, so nothing enters on a
// flushing edge.

// Leading-zero counter, 32 bits, built as a balanced tree. Each node reports
// whether its slice holds a one (v) and how many zeros lead that slice (c).
// A parent takes the high child's count when the high child has a one.
// Otherwise it takes half-width plus the low child's count.
module zbb_lzc32 (
  input  logic [31:0] i_data,
  output logic [4:0]  o_count,
  output logic        o_all_zero
);

  logic [15:0] w_v0;
  logic [15:0] w_c0;
  logic [7:0]  w_v1;
  logic [1:0]  w_c1 [8];
  logic [3:0]  w_v2;
  logic [2:0]  w_c2 [4];
  logic [1:0]  w_v3;
  logic [3:0]  w_c3 [2];

  // Leaf level: bit pairs.
  for (genvar p = 0; p < 16; p++) begin : g_l0
    assign w_v0[p] = i_data[2*p+1] | i_data[2*p];
    assign w_c0[p] = ~i_data[2*p+1];
  end

  // Slices of 4 bits.
  for (genvar p = 0; p < 8; p++) begin : g_l1
    assign w_v1[p] = w_v0[2*p+1] | w_v0[2*p];
    assign w_c1[p] = w_v0[2*p+1] ? {1'b0, w_c0[2*p+1]} : {1'b1, w_c0[2*p]};
  end

  // Slices of 8 bits.
  for (genvar p = 0; p < 4; p++) begin : g_l2
    assign w_v2[p] = w_v1[2*p+1] | w_v1[2*p];
    assign w_c2[p] = w_v1[2*p+1] ? {1'b0, w_c1[2*p+1]} : {1'b1, w_c1[2*p]};
  end

  // Slices of 16 bits.
  for (genvar p = 0; p < 2; p++) begin : g_l3
    assign w_v3[p] = w_v2[2*p+1] | w_v2[2*p];
    assign w_c3[p] = w_v2[2*p+1] ? {1'b0, w_c2[2*p+1]} : {1'b1, w_c2[2*p]};
  end

  // Root. The count is meaningless when the word is all zero; the caller
  // substitutes 32 in that case.
  assign o_count    = w_v3[1] ? {1'b0, w_c3[1]} : {1'b1, w_c3[0]};
  assign o_all_zero = ~(w_v3[1] | w_v3[0]);

endmodule

// Population count, 32 bits, as a five-level adder tree. Each level's sum
// is one bit wider than its inputs, so no level can overflow.
module zbb_popcnt32 (
  input  logic [31:0] i_data,
  output logic [5:0]  o_count
);

  logic [1:0] w_s0 [16];
  logic [2:0] w_s1 [8];
  logic [3:0] w_s2 [4];
  logic [4:0] w_s3 [2];

  for (genvar p = 0; p < 16; p++) begin : g_l0
    assign w_s0[p] = {1'b0, i_data[2*p+1]} + {1'b0, i_data[2*p]};
  end

  for (genvar p = 0; p < 8; p++) begin : g_l1
    assign w_s1[p] = {1'b0, w_s0[2*p+1]} + {1'b0, w_s0[2*p]};
  end

  for (genvar p = 0; p < 4; p++) begin : g_l2
    assign w_s2[p] = {1'b0, w_s1[2*p+1]} + {1'b0, w_s1[2*p]};
  end

  for (genvar p = 0; p < 2; p++) begin : g_l3
    assign w_s3[p] = {1'b0, w_s2[2*p+1]} + {1'b0, w_s2[2*p]};
  end

  assign o_count = {1'b0, w_s3[1]} + {1'b0, w_s3[0]};

endmodule

module zbb_count_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef enum logic [1:0] {
    OP_CLZ  = 2'b00,
    OP_CTZ  = 2'b01,
    OP_CPOP = 2'b10,
    OP_RSV  = 2'b11
  } op_e;

  // Stage 1 registers
  logic             r_s1_valid;
  op_e              r_s1_op;
  logic [XLEN-1:0]  r_s1_operand;
  logic [TAG_W-1:0] r_s1_tag;

  // Stage 2 registers
  logic             r_s2_valid;
  logic [XLEN-1:0]  r_s2_result;
  logic [TAG_W-1:0] r_s2_tag;
  logic             r_s2_illegal;

  // Handshake and datapath wires
  op_e              w_in_op;
  logic             w_s1_advance;
  logic             w_in_fire;
  logic [XLEN-1:0]  w_rev;
  logic [XLEN-1:0]  w_cond;
  logic [4:0]       w_lzc_count;
  logic             w_lzc_all_zero;
  logic [5:0]       w_lzc6;
  logic [5:0]       w_pop6;
  logic [5:0]       w_res6;
  logic             w_illegal;

  assign w_in_op = op_e'(in_op);

  // S1 may hand its entry to S2 when S2 is empty or is draining this cycle.
  assign w_s1_advance = ~r_s2_valid | out_ready;
  // S1 can take a new entry when it is empty or moving on. A flush blocks
  // entry so that a killed cycle cannot leak a new operation into the pipe.
  assign in_ready     = (~r_s1_valid | w_s1_advance) & ~flush;
  assign w_in_fire    = in_valid & in_ready;

  // Bit reversal of the operand, so CTZ can reuse the leading-zero counter.
  always_comb begin
    w_rev = '0;
    for (int i = 0; i < XLEN; i++) begin
      w_rev[i] = in_rs1[XLEN-1-i];
    end
  end

  // Operand conditioning: CTZ sees the reversed word. The reserved op sees
  // zero, so a garbage operand cannot toggle the count logic.
  always_comb begin
    w_cond = in_rs1;
    case (w_in_op)
      OP_CLZ:  w_cond = in_rs1;
      OP_CTZ:  w_cond = w_rev;
      OP_CPOP: w_cond = in_rs1;
      default: w_cond = '0;
    endcase
  end

  zbb_lzc32 u_lzc (
    .i_data     (r_s1_operand[31:0]),
    .o_count    (w_lzc_count),
    .o_all_zero (w_lzc_all_zero)
  );

  zbb_popcnt32 u_pop (
    .i_data  (r_s1_operand[31:0]),
    .o_count (w_pop6)
  );

  // An all-zero word has 32 leading zeros, which is exactly {1, 00000}.
  assign w_lzc6 = {w_lzc_all_zero, w_lzc_all_zero ? 5'd0 : w_lzc_count};

  // Select the S2 result by opcode. The reserved op yields 0 and flags illegal.
  always_comb begin
    w_res6    = 6'd0;
    w_illegal = 1'b0;
    case (r_s1_op)
      OP_CLZ:  w_res6 = w_lzc6;
      OP_CTZ:  w_res6 = w_lzc6;
      OP_CPOP: w_res6 = w_pop6;
      default: begin
        w_res6    = 6'd0;
        w_illegal = 1'b1;
      end
    endcase
  end

  // Stage valid bits: reset beats flush, and flush beats normal advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_s1_advance) begin
        r_s2_valid <= r_s1_valid;
      end
    end
  end

  // S1 payload loads only on an accepted input. Its contents are don't-care
  // while r_s1_valid is low, so it has no reset.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_s1_op      <= w_in_op;
      r_s1_operand <= w_cond;
      r_s1_tag     <= in_tag;
    end
  end

  // S2 payload: reset clears it so the outputs read zero during and after
  // reset. It loads only when a valid S1 entry moves down, and it holds
  // under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_result  <= '0;
      r_s2_tag     <= '0;
      r_s2_illegal <= 1'b0;
    end else if (!flush && w_s1_advance && r_s1_valid) begin
      r_s2_result  <= {{(XLEN-6){1'b0}}, w_res6};
      r_s2_tag     <= r_s1_tag;
      r_s2_illegal <= w_illegal;
    end
  end

  assign out_valid   = r_s2_valid;
  assign out_result  = r_s2_result;
  assign out_tag     = r_s2_tag;
  assign out_illegal = r_s2_illegal;

endmodule
